hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the three-stage (IF | EX | WB) RISC-V core. It sits beside the control unit and watches three things: the instruction in EX, the destination of the instruction in WB, and the resolved redirect. From these it drives PC hold, squash and operand-forward selects. It also owns the post-reset fetch warm-up, the post-redirect flush window and two 32-bit hazard performance counters.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/hazard_detect.sv | 18 +
 rtl/hazard_ctrl.sv | 86 ++++++++
 tb/tb_hazard_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM encoding, NOP constant and the rs-usage opcode classes for the IF|EX|WB core
package pipeline_pkg;
  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  // Opcode values mirror Opcode.vh
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: rs-usage decode of the EX instruction compared against the WB destination
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [31:0] x_instruction,
  input  logic        x_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_we,
  output logic        hz_a,
  output logic        hz_b
);
  logic live;
  logic unused_bits;
  assign unused_bits = ^{x_instruction[31:25], x_instruction[14:7]};
  assign live = x_valid && wb_reg_we && wb_rd != 5'd0;
  assign hz_a = live && uses_rs1(x_instruction[6:0]) && x_instruction[19:15] == wb_rd;
  assign hz_b = live && uses_rs2(x_instruction[6:0]) && x_instruction[24:20] == wb_rd;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing (warm-up, stall/forward, redirect flush, perf counters); FORWARD_EN_ selects forwarding over stalling
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int RESET_HOLD   = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x_instruction,
  input  logic        x_valid,
  input  logic        redirect,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_we,
  output logic        pc_reset,
  output logic        stall,
  output logic        kill_x,
  output logic        kill_f,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  state_t cur, nxt;
  logic [15:0] cnt, cnt_nxt;
  logic hz_a, hz_b, accept;
  hazard_detect u_detect (
    .x_instruction(x_instruction),
    .x_valid(x_valid),
    .wb_rd(wb_rd),
    .wb_reg_we(wb_reg_we),
    .hz_a(hz_a),
    .hz_b(hz_b)
  );
  assign state = cur;
  always_comb begin
    nxt = cur;
    cnt_nxt = cnt;
    pc_reset = 1'b0;
    stall = 1'b0;
    kill_x = 1'b0;
    kill_f = 1'b0;
    fwd_a = 1'b0;
    fwd_b = 1'b0;
    accept = 1'b0;
    if (cur == ST_RESET) begin
      pc_reset = 1'b1;
      kill_f = 1'b1;
      cnt_nxt = cnt - 16'd1;
      nxt = cnt <= 16'd1 ? ST_RUN : ST_RESET;
    end else if (cur == ST_FLUSH) begin
      kill_f = 1'b1;
      cnt_nxt = cnt - 16'd1;
      nxt = cnt <= 16'd1 ? ST_RUN : ST_FLUSH;
    end else begin
`ifdef FORWARD_EN_
      fwd_a = hz_a;
      fwd_b = hz_b;
`else
      stall = hz_a | hz_b;
      kill_x = stall;
`endif
      // A stalled redirect is re-evaluated next cycle with forwarded-through operands
      accept = redirect && x_valid && !stall;
      kill_f = accept;
      if (accept && FLUSH_CYCLES > 0) begin
        nxt = ST_FLUSH;
        cnt_nxt = 16'(FLUSH_CYCLES);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= ST_RESET;
      cnt <= 16'(RESET_HOLD);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      stall_cnt <= stall_cnt + {31'd0, stall};
      flush_cnt <= flush_cnt + {31'd0, accept};
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations for hazard_ctrl (RESET_HOLD=2, FLUSH_CYCLES=1)
module tb_hazard_ctrl;
`ifdef FORWARD_EN_
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [31:0] x_instruction;
  logic x_valid, redirect, wb_reg_we;
  logic [4:0] wb_rd;
  logic pc_reset, stall, kill_x, kill_f, fwd_a, fwd_b;
  logic [1:0] state;
  logic [31:0] stall_cnt, flush_cnt;
  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  hazard_ctrl #(.RESET_HOLD(2), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .x_instruction(x_instruction), .x_valid(x_valid),
    .redirect(redirect), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .pc_reset(pc_reset), .stall(stall), .kill_x(kill_x), .kill_f(kill_f),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic edge_();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] ins, input logic xv, input logic [4:0] rd, input logic we, input logic rdr);
    x_instruction = ins;
    x_valid = xv;
    wb_rd = rd;
    wb_reg_we = we;
    redirect = rdr;
    #1;
  endtask
  // Apply one operand vector in RUN, check fwd/stall, then clock it through
  task automatic hz_vec(input string tag, input logic [31:0] ins, input logic xv, input logic [4:0] rd, input logic we, input logic ea, input logic eb);
    drive(ins, xv, rd, we, 1'b0);
    check({tag, ".fwd_a"}, {31'd0, fwd_a}, {31'd0, FWD & ea});
    check({tag, ".fwd_b"}, {31'd0, fwd_b}, {31'd0, FWD & eb});
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, !FWD & (ea | eb)});
    check({tag, ".kill_x"}, {31'd0, kill_x}, {31'd0, !FWD & (ea | eb)});
    if (!FWD && (ea || eb)) exp_stall++;
    edge_();
    check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
  endtask
  initial begin
    rst = 1'b1;
    drive(32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) edge_();
    check("rst.state", {30'd0, state}, 32'd0);
    check("rst.pc_reset", {31'd0, pc_reset}, 32'd1);
    check("rst.kill_f", {31'd0, kill_f}, 32'd1);
    check("rst.stall", {31'd0, stall}, 32'd0);
    check("rst.cnts", stall_cnt | flush_cnt, 32'd0);
    rst = 1'b0;
    edge_();
    check("hold1.state", {30'd0, state}, 32'd0);
    check("hold1.pc_reset", {31'd0, pc_reset}, 32'd1);
    edge_();
    check("hold2.state", {30'd0, state}, 32'd1);
    check("hold2.pc_reset", {31'd0, pc_reset}, 32'd0);
    check("hold2.kill_f", {31'd0, kill_f}, 32'd0);
    hz_vec("add_x5x5", 32'h0052_8333, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    hz_vec("bubble", 32'h0052_8333, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    hz_vec("lui", 32'h0000_52b7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    hz_vec("auipc_rs1f5", 32'h0002_8297, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    hz_vec("addi_rs2f5", 32'h0050_8313, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    hz_vec("sw_rs2", 32'h0050_A023, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    hz_vec("addi_rs1", 32'h0002_8313, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    hz_vec("rd_x0", 32'h0000_0333, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    hz_vec("not_valid", 32'h0052_8333, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    hz_vec("rd_mismatch", 32'h0052_8333, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    drive(32'h0000_0013, 1'b1, 5'd0, 1'b0, 1'b1);
    check("redir.N.kill_f", {31'd0, kill_f}, 32'd1);
    check("redir.N.state", {30'd0, state}, 32'd1);
    edge_();
    drive(32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0);
    check("redir.N1.state", {30'd0, state}, 32'd2);
    check("redir.N1.kill_f", {31'd0, kill_f}, 32'd1);
    check("redir.N1.flush_cnt", flush_cnt, 32'd1);
    edge_();
    check("redir.N2.state", {30'd0, state}, 32'd1);
    check("redir.N2.kill_f", {31'd0, kill_f}, 32'd0);
    drive(32'h0052_8333, 1'b1, 5'd5, 1'b1, 1'b1);
    check("prio.stall", {31'd0, stall}, {31'd0, !FWD});
    check("prio.kill_f", {31'd0, kill_f}, {31'd0, FWD});
    if (!FWD) exp_stall++;
    edge_();
    check("prio.flush_cnt", flush_cnt, FWD ? 32'd2 : 32'd1);
    check("prio.stall_cnt", stall_cnt, exp_stall);
    drive(32'h0052_8333, 1'b1, 5'd5, 1'b0, 1'b1);
    check("prio2.kill_f", {31'd0, kill_f}, 32'd1);
    check("prio2.stall", {31'd0, stall}, 32'd0);
    edge_();
    check("prio2.flush_cnt", flush_cnt, 32'd2);
    check("prio2.state", {30'd0, state}, FWD ? 32'd1 : 32'd2);
    drive(32'h0000_0013, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    edge_();
    check("midrst.state", {30'd0, state}, 32'd0);
    check("midrst.pc_reset", {31'd0, pc_reset}, 32'd1);
    check("midrst.flush_cnt", flush_cnt, 32'd0);
    check("midrst.stall_cnt", stall_cnt, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
